// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: registered EX operand-forward selects, load-use stall
// insertion, branch/jump flush sequencing and saturating stall/flush counters.
module hazard_forward_unit #(
  parameter int RW         = 2,
  parameter int LOAD_STALL = 1,
  parameter int RF_BYPASS  = 1,
  parameter int ZERO_REG   = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_jump,
  input  logic [RW-1:0]    ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [RW-1:0]    mem_rd,
  input  logic             mem_reg_write,
  input  logic [RW-1:0]    wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       fsm_state
);

  // Control handshake: pc_write/ifid_write are enables that act in the cycle
  // they are driven; ifid_flush/idex_bubble squash the registers on that same
  // edge. There is no back-pressure path into this unit.

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

  state_t     state, state_next;
  logic [1:0] stall_left, stall_left_next;
  logic       stall_event, flush_event;
  logic       load_use;
  logic [1:0] fwd_a_next, fwd_b_next;

  function automatic logic reg_match(input logic [RW-1:0] rd, input logic we,
                                     input logic [RW-1:0] rs, input logic used);
    return we && (rd == rs) && used && !((ZERO_REG != 0) && (rd == '0));
  endfunction

  // A load in EX never forwards from EX: the load-use stall covers it.
  function automatic logic [1:0] fwd_code(input logic [RW-1:0] rs, input logic used,
                                          input logic [RW-1:0] e_rd, input logic e_we,
                                          input logic [RW-1:0] m_rd, input logic m_we,
                                          input logic [RW-1:0] w_rd, input logic w_we);
    if (reg_match(e_rd, e_we, rs, used))
      return 2'd2;
    else if (reg_match(m_rd, m_we, rs, used))
      return 2'd1;
    else if ((RF_BYPASS == 0) && reg_match(w_rd, w_we, rs, used))
      return 2'd3;
    else
      return 2'd0;
  endfunction

  always_comb begin
    fwd_a_next = fwd_code(id_rs1, id_use_rs1, ex_rd, ex_reg_write && !ex_mem_read,
                          mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b_next = fwd_code(id_rs2, id_use_rs2, ex_rd, ex_reg_write && !ex_mem_read,
                          mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    load_use   = ex_mem_read && (reg_match(ex_rd, 1'b1, id_rs1, id_use_rs1) ||
                                 reg_match(ex_rd, 1'b1, id_rs2, id_use_rs2));
  end

  always_comb begin
    state_next      = state;
    stall_left_next = stall_left;
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    idex_bubble     = 1'b0;
    stall_event     = 1'b0;
    flush_event     = 1'b0;
    if (!reset_n) begin
      state_next      = RUN;
      stall_left_next = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_event = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_event = 1'b1;
            if (LOAD_STALL > 1) begin
              stall_left_next = STALL_INIT;
              state_next      = STALL;
            end
          end else if (id_jump) begin
            ifid_flush  = 1'b1;
            flush_event = 1'b1;
            state_next  = FLUSH;
          end
        end
        STALL: begin
          if (ex_branch_taken) begin
            ifid_flush      = 1'b1;
            idex_bubble     = 1'b1;
            flush_event     = 1'b1;
            stall_left_next = 2'd0;
            state_next      = RUN;
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_event = 1'b1;
            if (stall_left <= 2'd1) begin
              stall_left_next = 2'd0;
              state_next      = RUN;
            end else begin
              stall_left_next = stall_left - 2'd1;
            end
          end
        end
        FLUSH: begin
          // ID holds the squashed slot, so only a taken branch matters here.
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_event = 1'b1;
          end
          state_next = RUN;
        end
        default: begin
          state_next      = RUN;
          stall_left_next = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RUN;
      stall_left  <= 2'd0;
      forward_a   <= 2'd0;
      forward_b   <= 2'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state      <= state_next;
      stall_left <= stall_left_next;
      if (idex_bubble) begin
        forward_a <= 2'd0;
        forward_b <= 2'd0;
      end else if (ifid_write) begin
        forward_a <= fwd_a_next;
        forward_b <= fwd_b_next;
      end
      if (stall_event && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (flush_event && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

  assign fsm_state = state;

endmodule
